// File: rtl/mux_stream_n.sv
// mux_stream_n: N-channel, W-bit streaming multiplexer with a registered
// output stage and valid/ready handshakes on every port.
//
// Channel choice is either explicit (mode_i = 0, sel_i) or round-robin
// (mode_i = 1, rotating pointer). The accepted channel index travels with
// the data on out_chan_o.
//
// Optional feature: define MUX_STREAM_LOCK_EN to add the in_last_i port and
// packet locking. A channel that starts a packet keeps the mux until it
// sends its last beat. Without the macro every beat arbitrates on its own.

module mux_stream_n #(
  parameter  int N  = 8,          // number of input channels, 2..16
  parameter  int W  = 8,          // data width per channel, 1..64
  localparam int SW = $clog2(N)   // select / channel index width
) (
  input  logic           clk,
  input  logic           rst_n,       // synchronous, active low
  input  logic           mode_i,      // 0 = explicit select, 1 = round-robin
  input  logic [SW-1:0]  sel_i,
  input  logic [N*W-1:0] in_data_i,   // channel k at [k*W +: W]
  input  logic [N-1:0]   in_valid_i,
  output logic [N-1:0]   in_ready_o,
`ifdef MUX_STREAM_LOCK_EN
  input  logic [N-1:0]   in_last_i,
`endif
  output logic [W-1:0]   out_data_o,
  output logic [SW-1:0]  out_chan_o,
  output logic           out_valid_o,
  input  logic           out_ready_i
);

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------

  // Adds an offset to a channel index and wraps modulo N. The pointer and
  // channel indices are always below N, so a single subtraction is enough
  // even when N is not a power of two.
  function automatic logic [SW-1:0] wrap_add(input logic [SW-1:0] base,
                                             input int            off);
    int sum;
    sum = int'(base) + off;
    if (sum >= N) sum = sum - N;
    return SW'(sum);
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------

  logic          out_valid_q, out_valid_d;
  logic [W-1:0]  out_data_q,  out_data_d;
  logic [SW-1:0] out_chan_q,  out_chan_d;
  logic [SW-1:0] ptr_q,       ptr_d;

`ifdef MUX_STREAM_LOCK_EN
  logic          lock_q,      lock_d;
  logic [SW-1:0] lock_ch_q,   lock_ch_d;
`endif

  // ---------------------------------------------------------------------------
  // Channel selection
  // ---------------------------------------------------------------------------

  logic          can_load;   // output stage is empty or draining this cycle
  logic          sel_ok;     // explicit select points at a real channel
  logic          rr_found;   // round-robin scan found a valid channel
  logic [SW-1:0] rr_ch;
  logic [SW-1:0] rr_cand;
  logic          chosen;     // some channel is offered the handshake
  logic [SW-1:0] ch;         // the channel offered the handshake
  logic          xfer;       // a beat moves into the output stage
  logic          last_beat;  // the accepted beat closes its packet

  assign can_load = !out_valid_q || out_ready_i;
  assign sel_ok   = (int'(sel_i) < N);

  // Round-robin: first valid channel starting at ptr_q, wrapping modulo N.
  always_comb begin
    // NOTE: every variable driven here gets a default first; a path that
    // leaves one unassigned would infer a latch.
    rr_found = 1'b0;
    rr_ch    = '0;
    rr_cand  = '0;
    for (int i = 0; i < N; i++) begin
      rr_cand = wrap_add(ptr_q, i);
      if (!rr_found && in_valid_i[rr_cand]) begin
        rr_found = 1'b1;
        rr_ch    = rr_cand;
      end
    end
  end

  // Final choice: mode picks the candidate, an open packet lock overrides it.
  always_comb begin
    if (mode_i) begin
      chosen = rr_found;
      ch     = rr_ch;
    end else begin
      chosen = sel_ok;
      ch     = sel_i;
    end
`ifdef MUX_STREAM_LOCK_EN
    if (lock_q) begin
      chosen = 1'b1;
      ch     = lock_ch_q;
    end
`endif
  end

  // Ready goes only to the chosen channel, and only while the output can load.
  // It is held low during reset so no producer sees a phantom accept.
  always_comb begin
    in_ready_o = '0;
    if (rst_n && chosen && can_load) in_ready_o[ch] = 1'b1;
  end

  assign xfer = rst_n && chosen && can_load && in_valid_i[ch];

`ifdef MUX_STREAM_LOCK_EN
  assign last_beat = in_last_i[ch];
`else
  // Without packet framing every beat is a complete packet.
  assign last_beat = 1'b1;
`endif

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------

  // Output stage: load on transfer, empty on drain without reload, else hold.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_chan_d  = out_chan_q;
    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = in_data_i[ch*W +: W];
      out_chan_d  = ch;
    end else if (out_ready_i) begin
      out_valid_d = 1'b0;
    end
  end

  // Round-robin pointer moves past the winner when a packet completes in mode 1.
  always_comb begin
    ptr_d = ptr_q;
    if (xfer && mode_i && last_beat) ptr_d = wrap_add(ch, 1);
  end

`ifdef MUX_STREAM_LOCK_EN
  // Lock opens on a non-last beat and closes on the last one.
  always_comb begin
    lock_d    = lock_q;
    lock_ch_d = lock_ch_q;
    if (xfer) begin
      lock_d = !last_beat;
      if (!last_beat) lock_ch_d = ch;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------

  // Output stage and pointer registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: out_data_q is a visible output register, not storage, so it is
      // reset to a defined zero along with the control state.
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_chan_q  <= '0;
      ptr_q       <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
      ptr_q       <= ptr_d;
    end
  end

`ifdef MUX_STREAM_LOCK_EN
  // Packet lock registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lock_q    <= 1'b0;
      lock_ch_q <= '0;
    end else begin
      lock_q    <= lock_d;
      lock_ch_q <= lock_ch_d;
    end
  end
`endif

  assign out_data_o  = out_data_q;
  assign out_chan_o  = out_chan_q;
  assign out_valid_o = out_valid_q;

  // ---------------------------------------------------------------------------
  // Invariants
  // ---------------------------------------------------------------------------

  // At most one producer is ever offered the handshake.
  always @(posedge clk) begin
    assert ($onehot0(in_ready_o));
  end

  // The pointer always names a real channel.
  always @(posedge clk) begin
    assert (int'(ptr_q) < N);
  end

  // A stalled beat stays put until the consumer takes it.
  property p_hold_on_stall;
    @(posedge clk) disable iff (!rst_n)
      (out_valid_q && !out_ready_i) |=>
        (out_valid_q && $stable(out_data_q) && $stable(out_chan_q));
  endproperty
  a_hold_on_stall: assert property (p_hold_on_stall);

endmodule
